// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronises rx, times each bit from the start edge and
// emits one-cycle rxReady / framing_error pulses alongside the received byte.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       rxReady,
    output logic [7:0] rxData,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);

    // The timer is cleared one edge after rx_s falls and is compared before it
    // increments, so it trails the true start-bit time by two cycles.
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic               rx_meta;
    logic               rx_s;
    state_t             state_q,     state_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic [2:0]         bit_cnt_q,   bit_cnt_d;
    logic [7:0]         shift_q,     shift_d;
    logic               stop_done_q, stop_done_d;
    logic               stop_bit_q,  stop_bit_d;
    logic               ready_d;
    logic               ferr_d;
    logic [7:0]         data_d;

    // NOTE: non-blocking assignments make rx_s take the previous rx_meta,
    // giving two real flop stages instead of one collapsed wire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            stop_done_q   <= 1'b0;
            stop_bit_q    <= 1'b0;
            rxReady       <= 1'b0;
            framing_error <= 1'b0;
            rxData        <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            stop_done_q   <= stop_done_d;
            stop_bit_q    <= stop_bit_d;
            rxReady       <= ready_d;
            framing_error <= ferr_d;
            rxData        <= data_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop_done_d = stop_done_q;
        stop_bit_d  = stop_bit_q;
        ready_d     = 1'b0;
        ferr_d      = 1'b0;
        data_d      = rxData;

        case (state_q)
            IDLE: begin
                timer_d     = '0;
                bit_cnt_d   = '0;
                stop_done_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (timer_q == START_LAST) begin
                    timer_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (stop_done_q) begin
                    // Outputs land the cycle after the stop mid-sample.
                    timer_d     = '0;
                    stop_done_d = 1'b0;
                    if (stop_bit_q) begin
                        ready_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else if (timer_q == BIT_LAST) begin
                    timer_d     = '0;
                    stop_done_d = 1'b1;
                    stop_bit_d  = rx_s;
                end
            end

            BREAK: begin
                timer_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and random 8N1 frames against an event model: each frame sent from
// idle must yield exactly one rxReady or framing_error at a fixed latency.
module tb_uart_rx_deserializer;

    localparam int C   = 8;
    localparam int LAT = 2 + C / 2 + 9 * C + 1;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       rxReady;
    logic       framing_error;
    logic       rx_busy;
    logic [7:0] rxData;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         at;
        logic       ferr;
        logic [7:0] data;
    } evt_t;

    evt_t got_q[$];
    evt_t exp_q[$];
    evt_t mon_ev;
    logic prev_r = 1'b0;
    logic prev_f = 1'b0;

    uart_rx_deserializer #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .rxReady       (rxReady),
        .rxData        (rxData),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Record every output pulse with the cycle of the edge that raised it.
    always @(negedge clk) begin
        if (rxReady || framing_error) begin
            mon_ev.at   = cyc;
            mon_ev.ferr = framing_error;
            mon_ev.data = rxData;
            got_q.push_back(mon_ev);
            check("pulse_exclusive", 32'(rxReady & framing_error), 32'd0);
            check("pulse_single_cycle", 32'((rxReady & prev_r) | (framing_error & prev_f)), 32'd0);
        end
        prev_r <= rxReady;
        prev_f <= framing_error;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int at, input logic ferr, input logic [7:0] data);
        evt_t e;
        e.at   = at;
        e.ferr = ferr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        evt_t g;
        evt_t e;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_cycle"}, g.at, e.at);
            check({tag, "_kind"}, 32'(g.ferr), 32'(e.ferr));
            if (!e.ferr) begin
                check({tag, "_data"}, 32'(g.data), 32'(e.data));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called at posedge+1; leaves rx at the stop value and returns the start edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int start);
        start = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(C);
        end
        rx = stop;
        tick(C);
    endtask

    initial begin
        int         s, s0, s1, s2, rel, gap, hold;
        logic [7:0] last_good;
        logic [7:0] d;
        logic       good;
        logic [7:0] aborted;

        tick(3);
        check("reset_rxReady", 32'(rxReady), 32'd0);
        check("reset_framing_error", 32'(framing_error), 32'd0);
        check("reset_rx_busy", 32'(rx_busy), 32'd0);
        check("reset_rxData", 32'(rxData), 32'h00);
        reset_n = 1'b1;
        tick(5);

        send_frame(8'hA5, 1'b1, s);
        expect_evt(s + LAT, 1'b0, 8'hA5);
        tick(10);
        compare_events("frame_a5");
        check("a5_rxData_held", 32'(rxData), 32'hA5);
        last_good = 8'hA5;

        s = cyc;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        check("glitch_busy_idle", 32'(rx_busy), 32'd0);
        tick(1);
        check("glitch_busy_start", 32'(rx_busy), 32'd1);
        tick(2);
        check("glitch_busy_presample", 32'(rx_busy), 32'd1);
        tick(1);
        check("glitch_busy_rejected", 32'(rx_busy), 32'd0);
        tick(10);
        compare_events("glitch");
        check("glitch_rxData", 32'(rxData), 32'(last_good));

        send_frame(8'h3C, 1'b0, s);
        expect_evt(s + LAT, 1'b1, 8'h00);
        tick(40);
        check("break_busy_held", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        rel = cyc;
        tick(2);
        check("break_busy_release_plus2", 32'(rx_busy), 32'd1);
        tick(1);
        check("break_busy_release_plus3", 32'(rx_busy), 32'd0);
        tick(5);
        compare_events("framing");
        check("framing_rxData_kept", 32'(rxData), 32'(last_good));
        check("framing_release_cycle", cyc - rel, 32'd8);

        send_frame(8'h00, 1'b1, s0);
        send_frame(8'hFF, 1'b1, s1);
        send_frame(8'h0A, 1'b1, s2);
        expect_evt(s0 + LAT, 1'b0, 8'h00);
        expect_evt(s1 + LAT, 1'b0, 8'hFF);
        expect_evt(s2 + LAT, 1'b0, 8'h0A);
        tick(10);
        compare_events("b2b");
        last_good = 8'h0A;

        aborted = 8'h55;
        s = cyc;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = aborted[i];
            tick(C);
        end
        rx = aborted[4];
        tick(C / 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_rxReady", 32'(rxReady), 32'd0);
        check("midreset_framing_error", 32'(framing_error), 32'd0);
        check("midreset_rx_busy", 32'(rx_busy), 32'd0);
        check("midreset_rxData", 32'(rxData), 32'h00);
        tick(C / 2);
        for (int i = 5; i < 8; i++) begin
            rx = aborted[i];
            tick(C);
        end
        rx = 1'b1;
        tick(C);
        check("held_reset_rx_busy", 32'(rx_busy), 32'd0);
        check("held_reset_rxData", 32'(rxData), 32'h00);
        tick(5);
        reset_n = 1'b1;
        tick(10);
        compare_events("aborted");
        send_frame(8'h0B, 1'b1, s);
        expect_evt(s + LAT, 1'b0, 8'h0B);
        tick(10);
        compare_events("after_reset");
        last_good = 8'h0B;

        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(d, good, s);
            expect_evt(s + LAT, !good, d);
            if (good) begin
                last_good = d;
                gap = $urandom_range(0, 5);
            end else begin
                hold = $urandom_range(0, 20);
                tick(hold);
                rx = 1'b1;
                gap = $urandom_range(1, 5);
            end
            tick(gap);
        end
        tick(10);
        compare_events("random");
        check("random_rxData_final", 32'(rxData), 32'(last_good));

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL have port: rxReady  output  1  one-cycle pulse when a valid byte is on rxData.
REQ-006 SHALL have port: rxData  output  8  last validly received byte.
REQ-007 SHALL have port: framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port: rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all further logic uses only the synchronized value (rx_s), which has 2 cycles of latency.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: on the first cycle rx_s is low, SHALL enter START and clear the bit-timer; all other inputs are ignored.
REQ-012 START: SHALL sample rx_s when the timer reaches CLKS_PER_BIT/2 (integer floor); if sampled low, enter DATA with timer cleared; if high, treat as a glitch and return to IDLE with no output pulse.
REQ-013 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles after the start mid-sample, 8 times, shifting LSB first into a shift register separate from rxData; after the 8th sample, enter STOP.
REQ-014 STOP: SHALL sample rx_s CLKS_PER_BIT cycles after the 8th data sample.
REQ-015 Stop sampled high: on the next cycle SHALL load rxData with the shift register, pulse rxReady for exactly 1 cycle, and return to IDLE.
REQ-016 Stop sampled low: on the next cycle SHALL pulse framing_error for 1 cycle, leave rxData unchanged, not pulse rxReady, and enter BREAK.
REQ-017 BREAK: SHALL remain until rx_s is high, then return to IDLE; a held-low line therefore yields exactly one framing_error and no spurious frames.
REQ-018 Latency: rxReady SHALL assert exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx-pin falling edge of the start bit (pin change aligned to a clk edge).
REQ-019 Back-to-back frames: a start bit beginning any time after the stop mid-sample SHALL be detected, with no dead cycle beyond the return to IDLE.
REQ-020 rxReady and framing_error SHALL never be high in the same cycle; neither SHALL be high on two consecutive cycles.
REQ-021 rxData SHALL hold its value between valid frames; there is no handshake or overrun detection, so the consumer takes each byte in the rxReady cycle.
REQ-022 The bit timer SHALL be at least clog2(CLKS_PER_BIT) bits wide and SHALL never wrap within a bit period.

Reset
REQ-023 reset_n low SHALL immediately force: FSM=IDLE, timer=0, bit count=0, shift register=0, rxData=0x00, rxReady=0, framing_error=0, rx_busy=0, and both synchronizer flops=1 (idle).
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, the block SHALL resync only on a new high-to-low transition of rx_s.

Verification (CLKS_PER_BIT=8)
REQ-025 Drive frame 0xA5 from idle at cycle 0 -> rxReady is high only on cycle 79, rxData=0xA5, framing_error never high.
REQ-026 Pulse rx low for 2 cycles, then hold high -> START rejects at the mid-sample, FSM returns to IDLE, no rxReady and no framing_error, rxData unchanged.
REQ-027 Send 0x3C with the stop bit driven low, then hold rx low for 40 cycles, then release -> exactly one framing_error pulse, rxData keeps its previous value, rx_busy stays high until 2 cycles after release, then IDLE.
REQ-028 Send 0x00, 0xFF, 0x0A back-to-back with single stop bits -> three rxReady pulses 80 cycles apart, carrying rxData 0x00, 0xFF, 0x0A in that order.
REQ-029 Assert reset_n low during data bit 4 of 0x55, release it, then send 0x0B -> all outputs are at reset values while reset is asserted, there is no pulse for the aborted frame, and the next rxReady carries 0x0B.
